display_sequencer: RTL and testbench
====================================

// Module: display_sequencer
// PURPOSE
//  Plays back a stored digit sequence (Simon-style pattern) on one seven-segment digit.
//  Drives the 4-bit code into the digit decoder (codes 0-7 = digits, 8 = 'G' game-over glyph).
//  Drives a blanking enable that the top level uses to force all segments off.
//  Sits between game control (loads the pattern, starts playback, flags game over) and the decoder.
// PARAMETERS
//  MAX_LEN     16          max stored sequence entries (power of 2, >=2)
//  ON_CYCLES   12_500_000  cycles each digit is lit (>=1)
//  OFF_CYCLES  2_500_000   blank cycles after each digit (>=1)
// PORTS
//  i_Clk           in   1            system clock
//  i_Rst           in   1            synchronous reset, active-high
//  i_Load_Valid    in   1            append i_Load_Digit to the sequence
//  i_Load_Digit    in   3            digit 0-7 to append
//  o_Load_Ready    out  1            1 = load accepted this cycle
//  i_Clear         in   1            empty the sequence / leave OVER state
//  i_Start         in   1            begin playback (single-cycle pulse)
//  i_Game_Over     in   1            show 'G' until cleared
//  o_Current       out  4            code for the digit decoder
//  o_Show          out  1            1 = segments lit, 0 = blank
//  o_Busy          out  1            1 = playback in progress (SHOW or GAP)
//  o_Done          out  1            one-cycle pulse at end of playback
//  o_Length        out  clog2(MAX_LEN)+1  stored entry count
// BEHAVIOUR
//  All outputs are registered. Reset values: state IDLE, count=0, o_Current=0, o_Show=0,
//   o_Busy=0, o_Done=0, o_Length=0, o_Load_Ready=1.
//  Priority at each edge: i_Rst > i_Game_Over > i_Clear > i_Start > i_Load_Valid.
//  States:
//   IDLE: o_Show=0, o_Load_Ready=(count<MAX_LEN).
//    Load: Valid&&Ready -> mem[count]<=digit, count++. Valid at full is dropped, no wrap.
//    i_Clear -> count=0; a load in the same cycle is discarded.
//    i_Start with count>0 -> SHOW, idx=0, timer=0.
//    i_Start with count==0 -> stay IDLE; o_Done=1 on the next cycle.
//   SHOW: o_Show=1, o_Current={1'b0,mem[idx]}, o_Busy=1, o_Load_Ready=0.
//    Held exactly ON_CYCLES cycles, then -> GAP, timer=0.
//   GAP: o_Show=0, o_Busy=1. Held exactly OFF_CYCLES cycles.
//    Then, if idx==count-1 -> IDLE with o_Done=1 for one cycle (the first IDLE cycle).
//    Otherwise idx++ -> SHOW.
//   OVER: o_Current=8, o_Show=1, o_Busy=0, o_Load_Ready=0.
//    i_Clear -> IDLE with count=0. All other inputs are ignored.
//  Timing: i_Start sampled at edge N -> o_Show=1 from edge N+1.
//   A full playback lasts count*(ON_CYCLES+OFF_CYCLES) cycles.
//   o_Done rises on the edge after the last GAP cycle.
//  i_Game_Over from any state (mid-playback included) -> OVER on the next edge.
//   Playback is abandoned and o_Done is not pulsed.
//  i_Start, i_Load_Valid and i_Clear are ignored while in SHOW or GAP.
//  Timer width is clog2(max(ON_CYCLES,OFF_CYCLES)). It counts 0..N-1 with no overflow.
//  Mid-operation reset returns every register to its reset value on that edge.
// TESTING (ON_CYCLES=4, OFF_CYCLES=2, MAX_LEN=4)
//  Load 3,5,1 then Start -> o_Current sequence 3,5,1, each with o_Show=1 for 4 cycles then 0 for 2.
//   o_Done pulses once, 18 cycles after Start.
//  Load 5 values -> o_Load_Ready=0 after the 4th, the 5th is dropped, o_Length=4.
//  Start with empty sequence -> o_Done=1 on the next cycle, o_Show stays 0, o_Busy stays 0.
//  Game_Over during the 2nd SHOW -> next cycle o_Current=8, o_Show=1, no o_Done.
//   Then Clear -> IDLE with o_Length=0.
//  Clear+Load_Valid in the same cycle -> o_Length=0; Load/Start pulses during playback have no effect.
//  Assert i_Rst mid-GAP -> next cycle all outputs at reset values, o_Load_Ready=1.

Source files
------------

// File: rtl/display_sequencer.sv
// -----------------------------------------------------------------------------
// display_sequencer
//
// Purpose:
//   Stores a short sequence of digits (0-7) and plays it back on a single
//   seven-segment digit. Each digit is lit for ON_CYCLES clocks and then
//   blanked for OFF_CYCLES clocks. A game-over request overrides everything
//   and shows the 'G' glyph (code 8) until the sequence is cleared.
//
// Ports:
//   i_Clk          system clock
//   i_Rst          synchronous reset, active-high
//   i_Load_Valid   append i_Load_Digit to the stored sequence
//   i_Load_Digit   digit 0-7 to append
//   o_Load_Ready   1 = a load presented now would be accepted
//   i_Clear        empty the sequence / leave the game-over state
//   i_Start        begin playback (single-cycle pulse)
//   i_Game_Over    show 'G' until cleared
//   o_Current      4-bit code for the digit decoder (0-7 digit, 8 = 'G')
//   o_Show         1 = segments lit, 0 = blank
//   o_Busy         1 = playback in progress
//   o_Done         one-cycle pulse when playback ends (or empty start)
//   o_Length       number of stored entries
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module display_sequencer #(
  parameter int MAX_LEN    = 16,
  parameter int ON_CYCLES  = 12_500_000,
  parameter int OFF_CYCLES = 2_500_000
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst,
  input  logic                      i_Load_Valid,
  input  logic [2:0]                i_Load_Digit,
  output logic                      o_Load_Ready,
  input  logic                      i_Clear,
  input  logic                      i_Start,
  input  logic                      i_Game_Over,
  output logic [3:0]                o_Current,
  output logic                      o_Show,
  output logic                      o_Busy,
  output logic                      o_Done,
  output logic [$clog2(MAX_LEN):0]  o_Length
);

  localparam int AW   = $clog2(MAX_LEN);
  localparam int CW   = AW + 1;
  localparam int TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  // A one-cycle phase would give a zero-width timer; keep at least one bit.
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [CW-1:0] FULL_COUNT = CW'(MAX_LEN);
  localparam logic [TW-1:0] ON_LAST    = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST   = TW'(OFF_CYCLES - 1);
  localparam logic [3:0]    GLYPH_G    = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2,
    OVER = 2'd3
  } state_t;

  // Sequence storage. Written only while IDLE, read when entering SHOW.
  logic [2:0] mem [MAX_LEN];

  state_t         state_reg,  state_next;
  logic [CW-1:0]  count_reg,  count_next;
  logic [AW-1:0]  idx_reg,    idx_next;
  logic [TW-1:0]  timer_reg,  timer_next;
  logic           wr_en;

  logic           done_reg,   done_next;
  logic           show_reg,   show_next;
  logic           busy_reg,   busy_next;
  logic           ready_reg,  ready_next;
  logic [3:0]     current_reg;

  // ---------------------------------------------------------------------------
  // State register (plus the datapath registers that travel with it)
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      idx_reg     <= '0;
      timer_reg   <= '0;
      done_reg    <= 1'b0;
      show_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      ready_reg   <= 1'b1;
      current_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      idx_reg   <= idx_next;
      timer_reg <= timer_next;
      done_reg  <= done_next;
      show_reg  <= show_next;
      busy_reg  <= busy_next;
      ready_reg <= ready_next;
      // Registered read: the entry being entered is fetched on the same edge
      // that moves the machine into SHOW, so the digit and o_Show line up.
      case (state_next)
        OVER:    current_reg <= GLYPH_G;
        SHOW:    current_reg <= {1'b0, mem[idx_next]};
        IDLE:    current_reg <= 4'd0;
        default: current_reg <= current_reg;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (wr_en) begin
      mem[count_reg[AW-1:0]] <= i_Load_Digit;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority: game over > clear > start > load.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    idx_next   = idx_reg;
    timer_next = timer_reg;
    done_next  = 1'b0;
    wr_en      = 1'b0;

    if (i_Game_Over) begin
      // Playback, if any, is abandoned silently: no done pulse.
      state_next = OVER;
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_Clear) begin
            count_next = '0;
          end else if (i_Start) begin
            if (count_reg != '0) begin
              state_next = SHOW;
              idx_next   = '0;
              timer_next = '0;
            end else begin
              // Nothing to play: report completion straight away.
              done_next = 1'b1;
            end
          end else if (i_Load_Valid && (count_reg < FULL_COUNT)) begin
            wr_en      = 1'b1;
            count_next = count_reg + CW'(1);
          end
        end

        SHOW: begin
          if (timer_reg == ON_LAST) begin
            state_next = GAP;
            timer_next = '0;
          end else begin
            timer_next = timer_reg + TW'(1);
          end
        end

        GAP: begin
          if (timer_reg == OFF_LAST) begin
            timer_next = '0;
            if ({1'b0, idx_reg} == (count_reg - CW'(1))) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end else begin
              state_next = SHOW;
              idx_next   = idx_reg + AW'(1);
            end
          end else begin
            timer_next = timer_reg + TW'(1);
          end
        end

        OVER: begin
          if (i_Clear) begin
            state_next = IDLE;
            count_next = '0;
          end
        end

        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic, evaluated on the upcoming state so every output is a flop.
  // ---------------------------------------------------------------------------
  always_comb begin
    show_next  = (state_next == SHOW) || (state_next == OVER);
    busy_next  = (state_next == SHOW) || (state_next == GAP);
    ready_next = (state_next == IDLE) && (count_next < FULL_COUNT);
  end

  assign o_Current    = current_reg;
  assign o_Show       = show_reg;
  assign o_Busy       = busy_reg;
  assign o_Done       = done_reg;
  assign o_Load_Ready = ready_reg;
  assign o_Length     = count_reg;

endmodule

// File: tb/tb_display_sequencer.sv
module tb_display_sequencer;

  localparam int MAX = 4;
  localparam int ON  = 4;
  localparam int OFF = 2;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic       i_Load_Valid = 1'b0;
  logic [2:0] i_Load_Digit = 3'd0;
  logic       o_Load_Ready;
  logic       i_Clear = 1'b0;
  logic       i_Start = 1'b0;
  logic       i_Game_Over = 1'b0;
  logic [3:0] o_Current;
  logic       o_Show;
  logic       o_Busy;
  logic       o_Done;
  logic [2:0] o_Length;

  int checks = 0;
  int errors = 0;

  // Reference model: the stored sequence as a plain queue.
  int q[$];

  display_sequencer #(
    .MAX_LEN   (MAX),
    .ON_CYCLES (ON),
    .OFF_CYCLES(OFF)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_Load_Valid(i_Load_Valid),
    .i_Load_Digit(i_Load_Digit),
    .o_Load_Ready(o_Load_Ready),
    .i_Clear     (i_Clear),
    .i_Start     (i_Start),
    .i_Game_Over (i_Game_Over),
    .o_Current   (o_Current),
    .o_Show      (o_Show),
    .o_Busy      (o_Busy),
    .o_Done      (o_Done),
    .o_Length    (o_Length)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    i_Load_Valid = 1'b0;
    i_Clear      = 1'b0;
    i_Start      = 1'b0;
    i_Game_Over  = 1'b0;
  endtask

  // Random pulses that must be ignored while playback is running.
  task automatic noise();
    i_Load_Valid = 1'($urandom_range(0, 1));
    i_Load_Digit = 3'($urandom_range(0, 7));
    i_Clear      = 1'($urandom_range(0, 1));
    i_Start      = 1'($urandom_range(0, 1));
  endtask

  task automatic load(input int d);
    bit exp_ready;
    exp_ready = (q.size() < MAX);
    check("load_ready", o_Load_Ready, exp_ready);
    i_Load_Valid = 1'b1;
    i_Load_Digit = 3'(d);
    tick();
    i_Load_Valid = 1'b0;
    if (exp_ready) q.push_back(d);
    check("load_len", o_Length, q.size());
    $display("load digit=%0d len=%0d", d, q.size());
  endtask

  task automatic clear();
    i_Clear = 1'b1;
    tick();
    i_Clear = 1'b0;
    q.delete();
    check("clear_len", o_Length, 0);
    check("clear_ready", o_Load_Ready, 1);
    $display("clear");
  endtask

  // Expected trace: each stored digit lit for ON cycles, blank for OFF
  // cycles, then a single done cycle back in idle.
  task automatic play(input bit with_noise);
    int n;
    n = q.size();
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    if (n == 0) begin
      check("empty_done", o_Done, 1);
      check("empty_show", o_Show, 0);
      check("empty_busy", o_Busy, 0);
    end else begin
      foreach (q[k]) begin
        for (int c = 0; c < ON; c++) begin
          check("show_on", o_Show, 1);
          check("show_cur", o_Current, q[k]);
          check("show_busy", o_Busy, 1);
          check("show_nodone", o_Done, 0);
          if (with_noise) noise();
          tick();
        end
        for (int c = 0; c < OFF; c++) begin
          check("gap_show", o_Show, 0);
          check("gap_busy", o_Busy, 1);
          check("gap_nodone", o_Done, 0);
          if (with_noise) noise();
          tick();
        end
      end
      quiet();
      check("end_done", o_Done, 1);
      check("end_busy", o_Busy, 0);
      check("end_show", o_Show, 0);
      check("end_len", o_Length, n);
      check("end_ready", o_Load_Ready, (n < MAX) ? 1 : 0);
    end
    tick();
    check("done_once", o_Done, 0);
    check("after_busy", o_Busy, 0);
    $display("play len=%0d noise=%0d", n, with_noise);
  endtask

  initial begin
    // Reset state
    quiet();
    i_Rst = 1'b1;
    tick();
    tick();
    check("rst_cur", o_Current, 0);
    check("rst_show", o_Show, 0);
    check("rst_busy", o_Busy, 0);
    check("rst_done", o_Done, 0);
    check("rst_len", o_Length, 0);
    check("rst_ready", o_Load_Ready, 1);
    i_Rst = 1'b0;
    tick();

    // Basic playback of 3,5,1
    load(3);
    load(5);
    load(1);
    play(1'b0);

    // Empty start
    clear();
    play(1'b0);

    // Overfill: fifth load dropped
    for (int i = 0; i < 5; i++) load(i + 2);
    check("full_len", o_Length, MAX);
    check("full_ready", o_Load_Ready, 0);
    play(1'b1);

    // Clear and load in the same cycle: load discarded
    i_Clear = 1'b1;
    i_Load_Valid = 1'b1;
    i_Load_Digit = 3'd6;
    tick();
    quiet();
    q.delete();
    check("clr_load_len", o_Length, 0);
    $display("clear+load");

    // Game over during the second digit
    load(2);
    load(6);
    load(7);
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    for (int c = 0; c < ON + OFF; c++) tick();
    check("go_pre_cur", o_Current, 6);
    i_Game_Over = 1'b1;
    tick();
    i_Game_Over = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check("go_cur", o_Current, 8);
      check("go_show", o_Show, 1);
      check("go_busy", o_Busy, 0);
      check("go_done", o_Done, 0);
      check("go_ready", o_Load_Ready, 0);
      i_Start      = 1'($urandom_range(0, 1));
      i_Load_Valid = 1'($urandom_range(0, 1));
      tick();
    end
    quiet();
    $display("game over");
    clear();
    check("go_clr_show", o_Show, 0);

    // Reset in the middle of a gap
    load(4);
    load(1);
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    for (int c = 0; c < ON + 1; c++) tick();
    check("pre_rst_busy", o_Busy, 1);
    i_Rst = 1'b1;
    tick();
    i_Rst = 1'b0;
    q.delete();
    check("mrst_cur", o_Current, 0);
    check("mrst_show", o_Show, 0);
    check("mrst_busy", o_Busy, 0);
    check("mrst_done", o_Done, 0);
    check("mrst_len", o_Length, 0);
    check("mrst_ready", o_Load_Ready, 1);
    $display("reset mid-gap");

    // Randomized rounds
    for (int r = 0; r < 20; r++) begin
      int nl;
      if ($urandom_range(0, 2) == 0) clear();
      nl = $urandom_range(0, 3);
      for (int i = 0; i < nl; i++) load($urandom_range(0, 7));
      play(1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
